// File: rtl/phase_acc_sched_if.sv
// Channel-side bus of the shared phase adder: level requests, steps and clears in;
// acks, phase registers and the retired-sum stream out.
interface phase_acc_sched_if #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
);
  logic [N_CH-1:0]    i_req;
  logic [N_CH*32-1:0] i_step;
  logic [N_CH-1:0]    i_clr;
  logic [N_CH-1:0]    o_ack;
  logic [N_CH*32-1:0] o_phase;
  logic               o_valid;
  logic [CH_W-1:0]    o_ch;
  logic [31:0]        o_sum;
  logic               o_busy;

  modport master (
    output i_req, i_step, i_clr,
    input  o_ack, o_phase, o_valid, o_ch, o_sum, o_busy
  );

  modport slave (
    input  i_req, i_step, i_clr,
    output o_ack, o_phase, o_valid, o_ch, o_sum, o_busy
  );
endinterface

// File: rtl/phase_acc_sched.sv
// Round-robin scheduler sharing one 32-bit carry-lookahead adder between N_CH
// phase accumulators: grant/fetch, add, write-back, then a per-channel ack.
module phase_acc_sched #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  phase_acc_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CH_W-1:0] r_ptr;
  logic [CH_W-1:0] w_gnt;
  logic            w_gnt_vld;
  logic [31:0]     w_step [N_CH];
  logic [31:0]     r_phase [N_CH];
  logic [31:0]     r_a_p0;
  logic [31:0]     r_b_p0;
  logic [CH_W-1:0] r_g_p0;
  logic [31:0]     r_sum_p1;
  logic [31:0]     w_sum;
  logic            r_cancel;
  logic            w_kill;
  logic [N_CH-1:0] r_ack;
  logic            r_valid;
  logic [CH_W-1:0] r_ch;
  logic [31:0]     r_sum;

  // 4-bit lookahead groups with a rippled group carry; the final carry-out is never formed.
  function automatic logic [31:0] cla_32(input logic [31:0] a, input logic [31:0] b,
                                         input logic c);
    logic [30:0] g;
    logic [31:0] p;
    logic [31:0] cy;
    logic [7:0]  gc;
    int          o;
    g  = a[30:0] & b[30:0];
    p  = a ^ b;
    cy = '0;
    gc = '0;
    gc[0] = c;
    for (int j = 0; j < 8; j++) begin
      o = 4 * j;
      cy[o]   = gc[j];
      cy[o+1] = g[o] | (p[o] & gc[j]);
      cy[o+2] = g[o+1] | (p[o+1] & g[o]) | (p[o+1] & p[o] & gc[j]);
      cy[o+3] = g[o+2] | (p[o+2] & g[o+1]) | (p[o+2] & p[o+1] & g[o])
              | (p[o+2] & p[o+1] & p[o] & gc[j]);
      if (j < 7) begin
        gc[j+1] = g[o+3] | (p[o+3] & g[o+2]) | (p[o+3] & p[o+2] & g[o+1])
                | (p[o+3] & p[o+2] & p[o+1] & g[o])
                | (p[o+3] & p[o+2] & p[o+1] & p[o] & gc[j]);
      end
    end
    return p ^ cy;
  endfunction

  for (genvar k = 0; k < N_CH; k++) begin : g_pack
    assign w_step[k]                    = bus.i_step[32*k +: 32];
    assign bus.o_phase[32*k +: 32]      = r_phase[k];
  end

  // Grant the requester closest after the last-served channel.
  always_comb begin
    int best;
    int d;
    best      = N_CH;
    d         = 0;
    w_gnt     = '0;
    w_gnt_vld = |bus.i_req;
    for (int k = 0; k < N_CH; k++) begin
      d = (k + 2 * N_CH - 1 - int'(r_ptr)) % N_CH;
      if (bus.i_req[k] && d < best) begin
        best  = d;
        w_gnt = CH_W'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_vld) w_state_nxt = S_ADD;
      S_ADD:   w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_sum  = cla_32(r_a_p0, r_b_p0, 1'b0);
  assign w_kill = r_cancel | bus.i_clr[r_g_p0];

  // Stage p0: operands captured at grant
  always_ff @(posedge i_clk) begin
    if (r_state == S_IDLE && w_gnt_vld) begin
      r_a_p0 <= r_phase[w_gnt];
      r_b_p0 <= w_step[w_gnt];
      r_g_p0 <= w_gnt;
    end
    // Stage p1: shared adder result
    if (r_state == S_ADD) begin
      r_sum_p1 <= w_sum;
    end
  end

  // Stage p2: write-back, ack and retired-sum stream
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= CH_W'(N_CH - 1);
      r_ack    <= '0;
      r_valid  <= 1'b0;
      r_ch     <= '0;
      r_sum    <= '0;
      r_cancel <= 1'b0;
      for (int k = 0; k < N_CH; k++) r_phase[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= '0;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_gnt_vld) r_cancel <= bus.i_clr[w_gnt];
        S_ADD:  r_cancel <= w_kill;
        S_WB: begin
          r_ack[r_g_p0] <= 1'b1;
          r_ptr         <= r_g_p0;
          if (!w_kill) begin
            r_phase[r_g_p0] <= r_sum_p1;
            r_valid         <= 1'b1;
            r_ch            <= r_g_p0;
            r_sum           <= r_sum_p1;
          end
        end
        default: ;
      endcase
      // A clear always wins over a same-edge write-back.
      for (int k = 0; k < N_CH; k++) begin
        if (bus.i_clr[k]) r_phase[k] <= '0;
      end
    end
  end

  assign bus.o_ack   = r_ack;
  assign bus.o_valid = r_valid;
  assign bus.o_ch    = r_ch;
  assign bus.o_sum   = r_sum;
  assign bus.o_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_phase_acc_sched.sv
// Directed bench for phase_acc_sched: a transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_phase_acc_sched;
  localparam int N    = 4;
  localparam int CH_W = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  phase_acc_sched_if #(.N_CH(N), .CH_W(CH_W)) bus ();

  phase_acc_sched #(.N_CH(N), .CH_W(CH_W)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0] m_ph [N];
  int          m_ptr;
  int          m_left;
  int          m_g;
  logic [31:0] m_sum;
  bit          m_kill;
  bit          m_on = 1'b0;
  logic [N-1:0] e_ack;
  logic        e_valid;
  logic        e_busy;
  int          e_ch;
  logic [31:0] e_sum;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) m_ph[c] = '0;
      m_ptr = N - 1; m_left = 0; m_kill = 0;
      e_ack = '0; e_valid = 0; e_busy = 0; e_ch = 0; e_sum = '0;
      m_on = 1'b1;
    end else if (m_on) begin
      bit found;
      e_ack = '0; e_valid = 0;
      if (m_left == 0) begin
        found = 0;
        for (int i = 1; i <= N; i++) begin
          int c;
          c = (m_ptr + i) % N;
          if (!found && bus.i_req[c]) begin found = 1; m_g = c; end
        end
        if (found) begin
          m_sum  = m_ph[m_g] + bus.i_step[32*m_g +: 32];
          m_kill = bus.i_clr[m_g];
          m_left = 2;
        end
      end else if (m_left == 2) begin
        m_kill = m_kill | bus.i_clr[m_g];
        m_left = 1;
      end else begin
        e_ack[m_g] = 1'b1;
        if (!(m_kill | bus.i_clr[m_g])) begin
          m_ph[m_g] = m_sum; e_valid = 1; e_ch = m_g; e_sum = m_sum;
        end
        m_ptr = m_g; m_left = 0;
      end
      for (int c = 0; c < N; c++) if (bus.i_clr[c]) m_ph[c] = '0;
      e_busy = (m_left != 0);
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      logic [127:0] ep;
      ep = '0;
      for (int c = 0; c < N; c++) ep[32*c +: 32] = m_ph[c];
      check("cyc_ack", bus.o_ack, e_ack);
      check("cyc_valid", bus.o_valid, e_valid);
      check("cyc_busy", bus.o_busy, e_busy);
      check("cyc_phase", bus.o_phase, ep);
      if (e_valid) begin
        check("cyc_ch", bus.o_ch, e_ch);
        check("cyc_sum", bus.o_sum, e_sum);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_req = '0; bus.i_clr = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic set_step(input int c, input logic [31:0] v);
    bus.i_step[32*c +: 32] = v;
  endtask

  function automatic logic [31:0] ph(input int c);
    return bus.o_phase[32*c +: 32];
  endfunction

  task automatic wait_ack(input bit drop, output int ch, output int cyc);
    ch = -1; cyc = 0;
    for (int k = 1; k <= 12 && ch < 0; k++) begin
      tick();
      if (|bus.o_ack) begin
        cyc = k;
        for (int c = 0; c < N; c++) if (bus.o_ack[c]) ch = c;
        if (drop) bus.i_req[ch] = 1'b0;
      end
    end
    if (ch < 0) begin
      n_cmp++; n_err++;
      $display("FAIL ack_timeout: got no ack expected one within 12 cycles (t=%0t)", $time);
    end
  endtask

  initial begin
    int ch, cyc, nack;
    rst_n = 1'b0; bus.i_req = '0; bus.i_clr = '0; bus.i_step = '0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_phase", bus.o_phase, 0);
    check("rst_ack", bus.o_ack, 0);
    check("rst_valid", bus.o_valid, 0);
    check("rst_ch", bus.o_ch, 0);
    check("rst_sum", bus.o_sum, 0);
    check("rst_busy", bus.o_busy, 0);

    // T1 single update of ch0
    set_step(0, 32'h10); bus.i_req = 4'b0001;
    wait_ack(1, ch, cyc);
    check("t1_ch", ch, 0); check("t1_lat", cyc, 3);
    check("t1_valid", bus.o_valid, 1); check("t1_och", bus.o_ch, 0);
    check("t1_sum", bus.o_sum, 32'h10); check("t1_ph0", ph(0), 32'h10);

    // T2 all channels held, round-robin order
    do_reset();
    set_step(0, 1); set_step(1, 2); set_step(2, 3); set_step(3, 4);
    bus.i_req = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      wait_ack(0, ch, cyc);
      check("t2_order", ch, n % 4);
      check("t2_gap", cyc, 3);
    end
    bus.i_req = '0;
    check("t2_ph0", ph(0), 2); check("t2_ph1", ph(1), 4);
    check("t2_ph2", ph(2), 6); check("t2_ph3", ph(3), 8);

    // T3 wrap past 2^32
    set_step(1, 32'hFFFF_FFEC); bus.i_req = 4'b0010;
    wait_ack(1, ch, cyc);
    check("t3_pre", ph(1), 32'hFFFF_FFF0);
    set_step(1, 32'h20); bus.i_req = 4'b0010;
    wait_ack(1, ch, cyc);
    check("t3_ch", ch, 1); check("t3_sum", bus.o_sum, 32'h10);
    check("t3_ph1", ph(1), 32'h10); check("t3_ph0", ph(0), 2);
    check("t3_ph2", ph(2), 6); check("t3_ph3", ph(3), 8);

    // T4 clear during ADD cancels the write-back
    set_step(2, 5); bus.i_req = 4'b0100;
    tick();
    check("t4_busy", bus.o_busy, 1);
    bus.i_clr = 4'b0100;
    tick();
    bus.i_clr = '0;
    wait_ack(1, ch, cyc);
    check("t4_ch", ch, 2); check("t4_lat", cyc, 1);
    check("t4_valid", bus.o_valid, 0); check("t4_ph2", ph(2), 0);
    check("t4_ph3", ph(3), 8);

    // T5 reset during ADD aborts the op
    set_step(3, 7); bus.i_req = 4'b1000;
    tick();
    rst_n = 1'b0; bus.i_req = '0;
    tick();
    rst_n = 1'b1;
    nack = 0;
    for (int k = 0; k < 5; k++) begin tick(); if (|bus.o_ack) nack++; end
    check("t5_noack", nack, 0); check("t5_ph3", ph(3), 0);
    set_step(0, 1); bus.i_req = 4'b1001;
    wait_ack(1, ch, cyc); check("t5_first", ch, 0);
    wait_ack(1, ch, cyc); check("t5_second", ch, 3); check("t5_sum", bus.o_sum, 7);

    // T6 rr pointer at ch0 favours ch2; step changes after grant are ignored
    bus.i_req = 4'b0001;
    wait_ack(1, ch, cyc); check("t6_pre", ch, 0);
    set_step(0, 32'h100); set_step(2, 32'h200); bus.i_req = 4'b0101;
    tick();
    set_step(2, 32'hDEAD_BEEF);
    wait_ack(1, ch, cyc);
    check("t6_first", ch, 2); check("t6_sum2", bus.o_sum, 32'h200);
    wait_ack(1, ch, cyc);
    check("t6_second", ch, 0); check("t6_sum0", bus.o_sum, 32'h102);

    // T7 clear in the grant cycle: cleared, op cancelled, ack still given
    bus.i_req = 4'b0001; bus.i_clr = 4'b0001;
    tick();
    bus.i_clr = '0;
    wait_ack(1, ch, cyc);
    check("t7_ch", ch, 0); check("t7_valid", bus.o_valid, 0);
    check("t7_ph0", ph(0), 0); check("t7_ph2", ph(2), 32'h200);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1);
  end
endmodule
